// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: datapath width, control-word
// field positions, opcodes and FSM state encoding.
package ex_pkg;

   localparam int W = 16;

   localparam int VALID_B  = 15;
   localparam int RW_B     = 14;
   localparam int R15W_B   = 13;
   localparam int DEST_MSB = 12;
   localparam int DEST_LSB = 9;
   localparam int MEM_MSB  = 8;
   localparam int MEM_LSB  = 4;
   localparam int OP_MSB   = 3;
   localparam int OP_LSB   = 0;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_SLL  = 4'h5;
   localparam logic [3:0] OP_SRL  = 4'h6;
   localparam logic [3:0] OP_SRA  = 4'h7;
   localparam logic [3:0] OP_MUL  = 4'h8;
   localparam logic [3:0] OP_DIV  = 4'h9;
   localparam logic [3:0] OP_PASS = 4'hA;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   function automatic logic [W-1:0] abs_w(input logic [W-1:0] x);
      return x[W-1] ? -x : x;
   endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative signed multiply (shift-add) and divide (restoring) on magnitudes,
// with sign fix-up; done pulses combinationally during the final step.
module muldiv_seq
   import ex_pkg::*;
#(
   parameter int ITER = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic         abort_i,
   input  logic         is_div_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [W-1:0] lo_o,
   output logic [W-1:0] hi_o
);

   localparam int CW = $clog2(ITER + 1);

   logic [CW-1:0]  cnt_q;
   logic [W-1:0]   a_q, a_d, hi_q, hi_d, b_q;
   logic           div_q, neg_lo_q, neg_hi_q;
   logic [W:0]     sum, shv, trial;
   logic           ge;
   logic [2*W-1:0] prod, prod_s;

   assign busy_o = (cnt_q != '0);
   assign done_o = (cnt_q == CW'(1));

   // a_q doubles as multiplier (shifted out LSB first) and dividend/quotient.
   always_comb begin
      sum   = {1'b0, hi_q} + (a_q[0] ? {1'b0, b_q} : '0);
      shv   = {hi_q, a_q[W-1]};
      trial = shv - {1'b0, b_q};
      ge    = ~trial[W];
      if (div_q) begin
         hi_d = ge ? trial[W-1:0] : shv[W-1:0];
         a_d  = {a_q[W-2:0], ge};
      end else begin
         hi_d = sum[W:1];
         a_d  = {sum[0], a_q[W-1:1]};
      end
      prod   = {hi_d, a_d};
      prod_s = neg_lo_q ? -prod : prod;
      if (div_q) begin
         lo_o = neg_lo_q ? -a_d : a_d;
         hi_o = neg_hi_q ? -hi_d : hi_d;
      end else begin
         lo_o = prod_s[W-1:0];
         hi_o = prod_s[2*W-1:W];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         a_q      <= '0;
         hi_q     <= '0;
         b_q      <= '0;
         div_q    <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
      end else if (abort_i) begin
         cnt_q <= '0;
      end else if (start_i) begin
         cnt_q    <= CW'(ITER);
         a_q      <= abs_w(a_i);
         b_q      <= abs_w(b_i);
         hi_q     <= '0;
         div_q    <= is_div_i;
         neg_lo_q <= a_i[W-1] ^ b_i[W-1];
         neg_hi_q <= a_i[W-1];
      end else if (busy_o) begin
         cnt_q <= cnt_q - CW'(1);
         a_q   <= a_d;
         hi_q  <= hi_d;
      end
   end

endmodule

// File: rtl/ex_stage_muldiv.sv
// Execute stage with single-cycle ALU, iterative MUL/DIV and EX/MEM registers.
// Define FAST_MUL_EN to compute MUL combinationally in one cycle.
module ex_stage_muldiv
   import ex_pkg::*;
#(
   parameter int ITER = 16
) (
   input  logic         C,
   input  logic         R,
   input  logic [W-1:0] ID1,
   input  logic [W-1:0] ID2,
   input  logic [W-1:0] ID15,
   input  logic [W-1:0] IC,
   input  logic         FL,
   output logic [W-1:0] OA,
   output logic [W-1:0] O15,
   output logic [W-1:0] OC,
   output logic         OV,
   output logic         S,
   output logic         DZ,
   output logic [0:0]   dbg_state_o
);

   logic [0:0]   state_q, state_d;
   logic [W-1:0] oa_q, oa_d, o15_q, o15_d, oc_q, oc_d, cap_q, cap_d;
   logic         ov_q, ov_d, dz_q, dz_d;
   logic [3:0]   op;
   logic         valid, is_seq, div_zero, start;
   logic [W-1:0] alu_lo, alu_hi, seq_lo, seq_hi;
   logic         seq_busy, seq_done;
`ifdef FAST_MUL_EN
   logic [2*W-1:0] fprod;
`endif

   assign op       = IC[OP_MSB:OP_LSB];
   assign valid    = IC[VALID_B];
   assign div_zero = (op == OP_DIV) && (ID2 == '0);
`ifdef FAST_MUL_EN
   assign is_seq   = (op == OP_DIV);
   assign fprod    = {{W{ID1[W-1]}}, ID1} * {{W{ID2[W-1]}}, ID2};
`else
   assign is_seq   = (op == OP_MUL) || (op == OP_DIV);
`endif
   assign start    = (state_q == ST_IDLE) && valid && is_seq && !div_zero && !FL;

   always_comb begin
      alu_lo = '0;
      alu_hi = ID15;
      case (op)
         OP_ADD:  alu_lo = ID1 + ID2;
         OP_SUB:  alu_lo = ID1 - ID2;
         OP_AND:  alu_lo = ID1 & ID2;
         OP_OR:   alu_lo = ID1 | ID2;
         OP_XOR:  alu_lo = ID1 ^ ID2;
         OP_SLL:  alu_lo = ID1 << ID2[3:0];
         OP_SRL:  alu_lo = ID1 >> ID2[3:0];
         OP_SRA:  alu_lo = $signed(ID1) >>> ID2[3:0];
`ifdef FAST_MUL_EN
         OP_MUL: begin
            alu_lo = fprod[W-1:0];
            alu_hi = fprod[2*W-1:W];
         end
`endif
         OP_PASS: alu_lo = ID1;
         default: alu_lo = '0;
      endcase
   end

   muldiv_seq #(.ITER(ITER)) u_seq (
      .clk_i    (C),
      .rst_ni   (R),
      .start_i  (start),
      .abort_i  (FL),
      .is_div_i (op == OP_DIV),
      .a_i      (ID1),
      .b_i      (ID2),
      .busy_o   (seq_busy),
      .done_o   (seq_done),
      .lo_o     (seq_lo),
      .hi_o     (seq_hi)
   );

   // Flush wins over both acceptance and completion.
   always_comb begin
      state_d = state_q;
      oa_d    = oa_q;
      o15_d   = o15_q;
      oc_d    = oc_q;
      ov_d    = ov_q;
      dz_d    = dz_q;
      cap_d   = cap_q;
      if (FL) begin
         state_d = ST_IDLE;
         ov_d    = 1'b0;
         oc_d    = '0;
         dz_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               dz_d = 1'b0;
               if (!valid) begin
                  ov_d = 1'b0;
                  oc_d = IC;
                  oa_d = '0;
               end else if (div_zero) begin
                  oa_d  = '1;
                  o15_d = ID1;
                  oc_d  = IC;
                  ov_d  = 1'b1;
                  dz_d  = 1'b1;
               end else if (is_seq) begin
                  state_d = ST_BUSY;
                  cap_d   = IC;
                  ov_d    = 1'b0;
               end else begin
                  oa_d  = alu_lo;
                  o15_d = alu_hi;
                  oc_d  = IC;
                  ov_d  = 1'b1;
               end
            end
            ST_BUSY: begin
               ov_d = 1'b0;
               if (seq_done || !seq_busy) begin
                  state_d = ST_IDLE;
                  oa_d    = seq_lo;
                  o15_d   = seq_hi;
                  oc_d    = cap_q;
                  ov_d    = seq_done;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge C or negedge R) begin
      if (!R) begin
         state_q <= ST_IDLE;
         oa_q    <= '0;
         o15_q   <= '0;
         oc_q    <= '0;
         ov_q    <= 1'b0;
         dz_q    <= 1'b0;
         cap_q   <= '0;
      end else begin
         state_q <= state_d;
         oa_q    <= oa_d;
         o15_q   <= o15_d;
         oc_q    <= oc_d;
         ov_q    <= ov_d;
         dz_q    <= dz_d;
         cap_q   <= cap_d;
      end
   end

   assign OA          = oa_q;
   assign O15         = o15_q;
   assign OC          = oc_q;
   assign OV          = ov_q;
   assign DZ          = dz_q;
   assign S           = (state_q == ST_BUSY);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Bench for ex_stage_muldiv: directed vector table, hand-written multi-cycle
// corner sequences, and random operations against an integer reference model.
module tb_ex_stage_muldiv;

  logic        C = 1'b0;
  logic        R;
  logic [15:0] ID1, ID2, ID15, IC;
  logic        FL;
  logic [15:0] OA, O15, OC;
  logic        OV, S, DZ;
  logic [0:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] ic, a, b, r15, oa, o15;
    logic        dz;
  } vec_t;

  vec_t vecs[$];

  ex_stage_muldiv dut (
    .C(C), .R(R), .ID1(ID1), .ID2(ID2), .ID15(ID15), .IC(IC), .FL(FL),
    .OA(OA), .O15(O15), .OC(OC), .OV(OV), .S(S), .DZ(DZ),
    .dbg_state_o(dbg_state_o)
  );

  always #5 C = ~C;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic edge_wait();
    @(posedge C);
    #1;
  endtask

  // Reference: plain integer arithmetic (C-like truncating division).
  function automatic void model(input logic [15:0] ic, a, b, r15,
                                output logic [15:0] oa, o15, output logic dz);
    int sa, sb, q, r;
    longint p;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    oa  = 16'h0;
    o15 = r15;
    dz  = 1'b0;
    case (ic[3:0])
      4'h0: oa = 16'(sa + sb);
      4'h1: oa = 16'(sa - sb);
      4'h2: oa = a & b;
      4'h3: oa = a | b;
      4'h4: oa = a ^ b;
      4'h5: oa = 16'(int'(a) * (1 << b[3:0]));
      4'h6: oa = 16'(int'(a) / (1 << b[3:0]));
      4'h7: oa = 16'(sa >>> b[3:0]);
      4'h8: begin
        p   = longint'(sa) * longint'(sb);
        oa  = p[15:0];
        o15 = p[31:16];
      end
      4'h9: begin
        if (b == 16'h0) begin
          oa  = 16'hFFFF;
          o15 = a;
          dz  = 1'b1;
        end else begin
          q   = sa / sb;
          r   = sa % sb;
          oa  = q[15:0];
          o15 = r[15:0];
        end
      end
      4'hA: oa = a;
      default: oa = 16'h0;
    endcase
  endfunction

  function automatic logic multi_cycle(input logic [15:0] ic, b);
    if (ic[3:0] == 4'h9) return (b != 16'h0);
`ifdef FAST_MUL_EN
    return 1'b0;
`else
    return (ic[3:0] == 4'h8);
`endif
  endfunction

  task automatic run_op(input logic [15:0] ic, a, b, r15, eoa, eo15,
                        input logic edz, input string tag);
    int bad;
    IC = ic; ID1 = a; ID2 = b; ID15 = r15;
    edge_wait();
    if (multi_cycle(ic, b)) begin
      chk({tag, "_accept_S"}, S, 1);
      chk({tag, "_accept_OV"}, OV, 0);
      // Garbage on the inputs must be ignored while busy.
      IC = {1'b1, 15'($urandom)}; ID1 = 16'($urandom); ID2 = 16'($urandom);
      ID15 = 16'($urandom);
      bad = 0;
      for (int i = 1; i < 16; i++) begin
        edge_wait();
        if (S !== 1'b1 || OV !== 1'b0 || dbg_state_o !== 1'b1) bad++;
      end
      chk({tag, "_busy_window"}, bad, 0);
      edge_wait();
    end
    chk({tag, "_OA"}, OA, eoa);
    chk({tag, "_O15"}, O15, eo15);
    chk({tag, "_OC"}, OC, ic);
    chk({tag, "_OV"}, OV, 1);
    chk({tag, "_S"}, S, 0);
    chk({tag, "_DZ"}, DZ, edz);
    IC = 16'h0;
  endtask

  task automatic add_vec(input logic [15:0] ic, a, b, r15, oa, o15, input logic dz);
    vec_t v;
    v.ic = ic; v.a = a; v.b = b; v.r15 = r15; v.oa = oa; v.o15 = o15; v.dz = dz;
    vecs.push_back(v);
  endtask

  task automatic start_seq(input logic [15:0] a, b, input int extra_edges);
`ifdef FAST_MUL_EN
    IC = 16'hE009;
`else
    IC = 16'hE008;
`endif
    ID1 = a; ID2 = b; ID15 = 16'h0;
    edge_wait();
    chk("seq_start_S", S, 1);
    IC = 16'hC000;
    repeat (extra_edges) edge_wait();
  endtask

  initial begin
    logic [15:0] ic, a, b, eoa, eo15;
    logic        edz;
    logic [3:0]  op;
    int          bad;
    string       tag;

    // Reset with arbitrary inputs applied.
    R = 1'b0; FL = 1'b0;
    IC = 16'hE008; ID1 = 16'($urandom); ID2 = 16'($urandom); ID15 = 16'($urandom);
    #3;
    chk("rst_OA", OA, 0);
    chk("rst_O15", O15, 0);
    chk("rst_OC", OC, 0);
    chk("rst_OV", OV, 0);
    chk("rst_S", S, 0);
    chk("rst_DZ", DZ, 0);
    repeat (2) edge_wait();
    chk("rst_hold_S", S, 0);
    IC = 16'h0;
    R = 1'b1;

    add_vec(16'hC000, 16'h7FFF, 16'h0001, 16'h1234, 16'h8000, 16'h1234, 0);
    add_vec(16'hC001, 16'h0000, 16'h0001, 16'h2222, 16'hFFFF, 16'h2222, 0);
    add_vec(16'hC002, 16'hF0F0, 16'h3C3C, 16'h0001, 16'h3030, 16'h0001, 0);
    add_vec(16'hC003, 16'hF0F0, 16'h0F00, 16'h0002, 16'hFFF0, 16'h0002, 0);
    add_vec(16'hC004, 16'hFFFF, 16'h00FF, 16'h0003, 16'hFF00, 16'h0003, 0);
    add_vec(16'hC005, 16'h0001, 16'h0014, 16'h0004, 16'h0010, 16'h0004, 0);
    add_vec(16'hC006, 16'h8000, 16'h000F, 16'h0005, 16'h0001, 16'h0005, 0);
    add_vec(16'hC007, 16'h8000, 16'h0004, 16'h0006, 16'hF800, 16'h0006, 0);
    add_vec(16'hE008, 16'hFFFE, 16'h0003, 16'h0007, 16'hFFFA, 16'hFFFF, 0);
    add_vec(16'hE009, 16'hFFF9, 16'h0002, 16'h0008, 16'hFFFD, 16'hFFFF, 0);
    add_vec(16'hE009, 16'h8000, 16'hFFFF, 16'h0009, 16'h8000, 16'h0000, 0);
    add_vec(16'hE009, 16'h1234, 16'h0000, 16'h000A, 16'hFFFF, 16'h1234, 1);
    add_vec(16'hC00A, 16'hABCD, 16'h0000, 16'h000B, 16'hABCD, 16'h000B, 0);
    add_vec(16'hC00B, 16'h1111, 16'h2222, 16'h000C, 16'h0000, 16'h000C, 0);
    add_vec(16'hE008, 16'h7FFF, 16'h7FFF, 16'h000D, 16'h0001, 16'h3FFF, 0);
    add_vec(16'hE008, 16'h8000, 16'h8000, 16'h000E, 16'h0000, 16'h4000, 0);
    add_vec(16'hE009, 16'h0007, 16'hFFFE, 16'h000F, 16'hFFFD, 16'h0001, 0);
    add_vec(16'hE009, 16'h1234, 16'h0001, 16'h0010, 16'h1234, 16'h0000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      tag = $sformatf("vec%0d", i);
      run_op(vecs[i].ic, vecs[i].a, vecs[i].b, vecs[i].r15,
             vecs[i].oa, vecs[i].o15, vecs[i].dz, tag);
    end

    // Invalid entry: bubble with OC passed through and O15 held.
    run_op(16'hC000, 16'h0001, 16'h0001, 16'h5A5A, 16'h0002, 16'h5A5A, 0, "pre_inv");
    IC = 16'h4000; ID15 = 16'h1111;
    edge_wait();
    chk("inv_OV", OV, 0);
    chk("inv_OC", OC, 16'h4000);
    chk("inv_OA", OA, 0);
    chk("inv_O15", O15, 16'h5A5A);

    // Flush in the middle of an iterative op.
    start_seq(16'hFFFE, 16'h0003, 4);
    FL = 1'b1;
    edge_wait();
    FL = 1'b0;
    chk("flush_mid_OV", OV, 0);
    chk("flush_mid_S", S, 0);
    chk("flush_mid_OC", OC, 0);
    chk("flush_mid_state", dbg_state_o, 0);
    run_op(16'hC000, 16'h0001, 16'h0002, 16'h0000, 16'h0003, 16'h0000, 0, "post_flush");

    // Flush beats acceptance of a valid single-cycle op.
    IC = 16'hC000; ID1 = 16'h0005; ID2 = 16'h0005; FL = 1'b1;
    edge_wait();
    FL = 1'b0;
    chk("flush_acc_OV", OV, 0);
    chk("flush_acc_OC", OC, 0);

    // Flush on the completion edge suppresses the result.
    start_seq(16'h0064, 16'h0007, 15);
    FL = 1'b1;
    edge_wait();
    FL = 1'b0;
    chk("flush_done_OV", OV, 0);
    chk("flush_done_S", S, 0);

    // Asynchronous reset in the middle of an iterative op.
    run_op(16'hC00A, 16'h1234, 16'h0000, 16'h5678, 16'h1234, 16'h5678, 0, "pre_rst");
    start_seq(16'hFFFE, 16'h0003, 7);
    #2;
    R = 1'b0;
    #1;
    chk("arst_OA", OA, 0);
    chk("arst_O15", O15, 0);
    chk("arst_OC", OC, 0);
    chk("arst_S", S, 0);
    IC = 16'h0;
    edge_wait();
    R = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      edge_wait();
      if (OV !== 1'b0 || S !== 1'b0) bad++;
    end
    chk("arst_no_result", bad, 0);
    run_op(16'hC000, 16'h0010, 16'h0020, 16'h0000, 16'h0030, 16'h0000, 0, "post_rst");

    // Random operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) b = 16'h0;
      if (op == 4'h9 && $urandom_range(0, 5) == 0) begin
        a = 16'h8000; b = 16'hFFFF;
      end
      ic = {1'b1, 11'($urandom), op};
      ID15 = 16'($urandom);
      model(ic, a, b, ID15, eoa, eo15, edz);
      tag = $sformatf("rnd%0d_op%0h", n, op);
      run_op(ic, a, b, ID15, eoa, eo15, edz, tag);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage_muldiv.md
Name: ex_stage_muldiv

Overview:
- Execute stage directly downstream of the ID/EX buffer. Consumes its three operand words (ID1, ID2, ID15) and its 16-bit control word.
- Performs the ALU operation, including signed multiply and divide that write a second result to R15 (high product / remainder).
- Registers the results as the EX/MEM buffer.
- Single-cycle ops complete in one clock. MUL/DIV run iteratively over 16 cycles and stall the upstream pipeline while they run.

Parameters:
- W, 16, datapath width; all arithmetic rules below assume W=16.
- ITER, 16, iteration count for sequential MUL/DIV; must equal W.

Ports:
- C  input  1  clock; all state updates on the rising edge.
- R  input  1  reset, asynchronous, active-low; R=0 clears all state immediately.
- ID1  input  16  operand A (from ID/EX OD1).
- ID2  input  16  operand B (from ID/EX OD2).
- ID15  input  16  R15 operand (from ID/EX OD15).
- IC  input  16  control word (from ID/EX OC).
- FL  input  1  synchronous flush from branch resolution.
- OA  output  16  primary result (EX/MEM).
- O15  output  16  R15 result (EX/MEM).
- OC  output  16  control word forwarded to EX/MEM.
- OV  output  1  EX/MEM entry valid.
- S  output  1  stall to upstream; ID/EX holds its outputs while S=1.
- DZ  output  1  divide-by-zero flag; qualified by OV.

Behaviour:
- Control word fields:
  - IC[15] valid
  - IC[14] reg write
  - IC[13] R15 write
  - IC[12:9] destination register
  - IC[8:4] memory controls, passed through unchanged
  - IC[3:0] opcode
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA; shift amount is ID2[3:0]
  - 8 MUL, 9 DIV, A PASS (OA=ID1)
  - B-F NOP: OA=0, O15=ID15
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^16.
  - Non-MUL/DIV ops: O15=ID15.
- Reset state: OA=0, O15=0, OC=0, OV=0, S=0, DZ=0. FSM enters IDLE and the iteration counter clears to 0.
- FSM states: IDLE, BUSY.
- IDLE, entry valid and single-cycle op (IC[15]=1, opcode not 8/9):
  - Next edge: OA/O15/OC latched, OV=1, DZ=0. Latency 1.
- IDLE, IC[15]=0:
  - Next edge: OV=0, OC=IC, OA=0, O15 holds.
- IDLE, IC[15]=1 and opcode 8 or 9:
  - Accept edge k: operands and control word captured, counter=ITER, go to BUSY, S=1 after edge k, OV=0.
- BUSY:
  - One shift-add (MUL) or restoring step (DIV) per edge; counter decrements.
  - Edge k+16, final step: OA/O15/OC written, OV=1, S=0, return to IDLE.
  - OV=0 throughout BUSY, except after edge k+16.
  - Inputs ID*/IC are ignored while BUSY.
- MUL: signed 16x16 to 32. OA=product[15:0], O15=product[31:16].
- DIV: signed, quotient truncates toward zero; remainder takes the sign of the dividend.
  - OA=quotient, O15=remainder.
  - 0x8000/0xFFFF: OA=0x8000, O15=0, DZ=0.
  - ID2=0: no iteration; next edge OA=0xFFFF, O15=ID1, DZ=1, OV=1. Latency 1.
- FL=1 at an edge, in any state:
  - Aborts BUSY and forces IDLE.
  - Outputs a bubble: OV=0, OC=0, S=0.
  - FL has priority over acceptance and over completion.
- R asserted mid-operation: immediate return to reset values. No partial result appears.

Optional Feature:
- FAST_MUL_EN defined: MUL is computed combinationally and completes in 1 cycle like ADD; S never asserts for MUL. DIV is unchanged.
- FAST_MUL_EN undefined: sequential 16-cycle MUL as above.

Decomposition:
- Shared package ex_pkg holds:
  - opcode localparams
  - control-field bit positions (VALID_B, RW_B, R15W_B, DEST_MSB/LSB, OP_MSB/LSB)
  - FSM state encoding
  - W
- One sub-module, muldiv_seq, owns:
  - the iterative MUL/DIV datapath and counter
  - start/done handshake, with done a one-cycle pulse
  - sign fix-up
- ex_stage_muldiv holds the FSM, single-cycle ALU, flush/stall logic and the EX/MEM registers.

Test Plan:
- Reset low at t=0 with arbitrary inputs -> all outputs 0. Release, IC=0xC000 (ADD, valid, RW), ID1=0x7FFF, ID2=0x0001 -> next edge OA=0x8000, OV=1, S=0.
- IC=0xE008 MUL, ID1=0xFFFE (-2), ID2=0x0003 -> S=1 for 16 cycles, OV=0 meanwhile; edge k+16: OA=0xFFFA, O15=0xFFFF, OV=1. With FAST_MUL_EN defined: same values after 1 edge, S stays 0.
- DIV ID1=0xFFF9 (-7), ID2=0x0002 -> after 16 cycles OA=0xFFFD, O15=0xFFFF. Also check 0x8000/0xFFFF -> OA=0x8000, O15=0.
- DIV ID2=0 -> next edge OA=0xFFFF, O15=ID1, DZ=1, S never asserts.
- MUL started, FL=1 at iteration 5 -> next edge OV=0, S=0, IDLE. A following ADD completes normally in 1 cycle.
- MUL started, R pulsed low at iteration 8 -> outputs clear immediately (asynchronously). No result appears after release.
